// File: rtl/pyrm_fetch_queue_if.sv
// Fetch-unit bus: redirect input, instruction-memory request/response and decode-side output.
// master is the fetch unit; slave is the surrounding pipeline/memory.
interface pyrm_fetch_queue_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32
);
    logic [XLEN-1:0] redirect_pc_pyri;
    logic            redirect_valid_pyri;
    logic [XLEN-1:0] imem_req_addr_pyro;
    logic            imem_req_valid_pyro;
    logic            imem_req_retry_pyri;
    logic [ILEN-1:0] imem_rsp_data_pyri;
    logic            imem_rsp_valid_pyri;
    logic [XLEN-1:0] pc_pyro;
    logic [ILEN-1:0] inst_pyro;
    logic            inst_valid_pyro;
    logic            inst_retry_pyri;

    modport master (
        input  redirect_pc_pyri, redirect_valid_pyri, imem_req_retry_pyri,
        input  imem_rsp_data_pyri, imem_rsp_valid_pyri, inst_retry_pyri,
        output imem_req_addr_pyro, imem_req_valid_pyro, pc_pyro, inst_pyro, inst_valid_pyro
    );

    modport slave (
        output redirect_pc_pyri, redirect_valid_pyri, imem_req_retry_pyri,
        output imem_rsp_data_pyri, imem_rsp_valid_pyri, inst_retry_pyri,
        input  imem_req_addr_pyro, imem_req_valid_pyro, pc_pyro, inst_pyro, inst_valid_pyro
    );
endinterface

// File: rtl/pyrm_fetch_queue.sv
// RISC-V fetch unit: sequential prefetch into a DEPTH-entry queue, local JAL resolution,
// stall on BRANCH/JALR until redirect, and in-order discard of stale memory responses.
module pyrm_fetch_queue #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input logic                clk,
    input logic                reset_pyri,
    pyrm_fetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    // Redirects can stack up discards beyond DEPTH while memory is slow, so drop gets headroom.
    localparam int unsigned DW = CW + 3;
    localparam logic [6:0]  OpJal    = 7'b1101111;
    localparam logic [6:0]  OpBranch = 7'b1100011;
    localparam logic [6:0]  OpJalr   = 7'b1100111;

    if (ILEN != 32) begin : g_ilen_check
        $error("pyrm_fetch_queue: ILEN must be 32");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("pyrm_fetch_queue: DEPTH must be a power of two >= 2");
    end

    typedef enum logic [0:0] {StRun, StWaitBr} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [ILEN-1:0] q_inst [DEPTH];
    logic [XLEN-1:0] tag_q  [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [CW-1:0]   count_q, count_d, out_q, out_d, out_after;
    logic [DW-1:0]   drop_q, drop_d;

    logic            redirect, req_valid, req_acc, rsp_drop, rsp_take, enq, deq, inst_valid;
    logic            flush;
    logic [CW:0]     inflight;
    logic [XLEN-1:0] rsp_pc, jal_imm;
    logic [ILEN-1:0] rsp_data;

    assign redirect  = bus.redirect_valid_pyri;
    assign rsp_data  = bus.imem_rsp_data_pyri;
    assign inflight  = {1'b0, count_q} + {1'b0, out_q};
    assign req_valid = reset_pyri && (state_q == StRun) && (inflight < (CW+1)'(DEPTH)) && !redirect;
    assign req_acc   = req_valid && !bus.imem_req_retry_pyri;
    assign rsp_drop  = bus.imem_rsp_valid_pyri && (drop_q != '0);
    assign rsp_take  = bus.imem_rsp_valid_pyri && (drop_q == '0) && (out_q != '0);
    assign rsp_pc    = tag_q[tag_rd_q];
    assign jal_imm   = {{(XLEN-21){rsp_data[31]}}, rsp_data[31], rsp_data[19:12], rsp_data[20],
                        rsp_data[30:21], 1'b0};
    assign inst_valid = reset_pyri && (count_q != '0);
    assign enq       = rsp_take && !redirect;
    assign deq       = inst_valid && !bus.inst_retry_pyri && !redirect;

    assign bus.imem_req_addr_pyro  = fetch_pc_q;
    assign bus.imem_req_valid_pyro = req_valid;
    assign bus.inst_valid_pyro     = inst_valid;
    assign bus.pc_pyro             = inst_valid ? q_pc[head_q] : '0;
    assign bus.inst_pyro           = inst_valid ? q_inst[head_q] : '0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        count_d    = count_q;
        out_d      = out_q;
        drop_d     = drop_q;
        flush      = 1'b0;
        out_after  = out_q + CW'(req_acc) - CW'(rsp_take);
        if (redirect) begin
            // A same-cycle response has already consumed one of the in-flight slots.
            state_d    = StRun;
            fetch_pc_d = bus.redirect_pc_pyri;
            head_d     = tail_q;
            count_d    = '0;
            out_d      = '0;
            drop_d     = drop_q + DW'(out_q) - DW'(rsp_drop || rsp_take);
            tag_rd_d   = tag_wr_q;
        end else begin
            if (req_acc) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                tag_wr_d   = tag_wr_q + PW'(1);
            end
            if (rsp_drop) drop_d = drop_q - DW'(1);
            if (rsp_take) tag_rd_d = tag_rd_q + PW'(1);
            if (enq) tail_d = tail_q + PW'(1);
            if (deq) head_d = head_q + PW'(1);
            count_d = count_q + CW'(enq) - CW'(deq);
            out_d   = out_after;
            if (rsp_take) begin
                case (rsp_data[6:0])
                    OpJal: begin
                        fetch_pc_d = rsp_pc + jal_imm;
                        flush      = 1'b1;
                    end
                    OpBranch, OpJalr: begin
                        state_d = StWaitBr;
                        flush   = 1'b1;
                    end
                    default: ;
                endcase
            end
            // Everything still in flight, including a request accepted this cycle, is stale.
            if (flush) begin
                drop_d   = DW'(out_after);
                out_d    = '0;
                tag_rd_d = tag_wr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_pyri) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[tail_q]   <= rsp_pc;
            q_inst[tail_q] <= rsp_data;
        end
        if (req_acc) tag_q[tag_wr_q] <= fetch_pc_q;
    end
endmodule

// File: tb/tb_pyrm_fetch_queue.sv
// Scoreboarded random bench: a program-walk model predicts the decode-side pc/inst stream,
// and an in-order memory model with random latency/retry serves the fetch requests.
module tb_pyrm_fetch_queue;
    localparam int unsigned XLEN     = 64;
    localparam int unsigned ILEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    typedef struct {logic [63:0] pc; logic [31:0] inst;} ent_t;
    typedef struct {logic [63:0] addr; int due;} req_t;

    logic clk = 1'b0;
    logic reset_pyri;
    pyrm_fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

    pyrm_fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .reset_pyri(reset_pyri),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, hs_count = 0, rst_edges = 0, phase = 0;
    ent_t exp_q[$];
    req_t pend_q[$];
    logic [63:0] walk_pc;
    bit walk_stop;
    int prog_mode = 0;
    int mem_retry_pct = 0, dec_retry_pct = 0, rsp_stall_pct = 0, max_lat = 0;
    bit hold_dec_retry = 0, hold_mem_retry = 0, spurious = 0, rsp_ctrl = 0;
    bit redir_prev = 0, prev_stall = 0, prev_rsp_ctrl = 0;
    logic [63:0] redir_tgt, prev_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Program image: a pure function of the address. kind 0 = sequential, 1 = jump, 2 = stop.
    function automatic void gen(input logic [63:0] a, output logic [31:0] inst, output int kind,
                                output logic [63:0] off);
        logic [31:0] h;
        logic [20:0] o;
        logic [4:0]  rd;
        h    = a[33:2] * 32'h9E37_79B1;
        h    = h ^ (h >> 15);
        rd   = h[20:16];
        o    = {{11{h[29]}}, h[29:22], 2'b00};
        off  = {{43{o[20]}}, o};
        kind = 0;
        inst = 32'h0000_0013;
        if (prog_mode != 0) begin
            case (h[3:0])
                4'd0, 4'd1: begin
                    inst = {o[20], o[10:1], o[11], o[19:12], rd, 7'h6f};
                    kind = 1;
                end
                4'd2: begin
                    inst = {7'h0, h[24:20], h[19:15], 3'b000, 5'h0, 7'h63};
                    kind = 2;
                end
                4'd3: begin
                    inst = {12'h0, h[19:15], 3'b000, rd, 7'h67};
                    kind = 2;
                end
                4'd4: inst = {h[31:12], rd, 7'h37};
                default: inst = {h[31:20], h[19:15], 3'b000, rd, 7'h13};
            endcase
        end
    endfunction

    task automatic extend();
        logic [31:0] inst;
        logic [63:0] off;
        int kind;
        while (!walk_stop && exp_q.size() < 16) begin
            gen(walk_pc, inst, kind, off);
            exp_q.push_back('{walk_pc, inst});
            if (kind == 1) walk_pc = walk_pc + off;
            else if (kind == 2) walk_stop = 1;
            else walk_pc = walk_pc + 64'd4;
        end
    endtask

    task automatic start_walk(input logic [63:0] pc);
        exp_q.delete();
        walk_pc   = pc;
        walk_stop = 0;
        extend();
    endtask

    // Drive one cycle of inputs just after the active edge.
    task automatic step(input bit do_redir, input logic [63:0] tgt);
        logic [31:0] inst;
        logic [63:0] off;
        int kind;
        @(posedge clk);
        #1;
        cyc++;
        bus.redirect_valid_pyri = do_redir;
        bus.redirect_pc_pyri    = do_redir ? tgt : {$urandom, $urandom};
        if (do_redir) start_walk(tgt);
        bus.imem_rsp_valid_pyri = 1'b0;
        bus.imem_rsp_data_pyri  = $urandom;
        rsp_ctrl = 0;
        if (spurious) begin
            bus.imem_rsp_valid_pyri = 1'b1;
            bus.imem_rsp_data_pyri  = 32'h0000_0013;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc
                     && $urandom_range(0, 99) >= rsp_stall_pct) begin
            gen(pend_q[0].addr, inst, kind, off);
            bus.imem_rsp_valid_pyri = 1'b1;
            bus.imem_rsp_data_pyri  = inst;
            rsp_ctrl = (kind != 0);
            void'(pend_q.pop_front());
        end
        bus.imem_req_retry_pyri = hold_mem_retry || ($urandom_range(0, 99) < mem_retry_pct);
        bus.inst_retry_pyri     = hold_dec_retry || ($urandom_range(0, 99) < dec_retry_pct);
    endtask

    always @(posedge clk) rst_edges = reset_pyri ? 0 : rst_edges + 1;

    // Monitor: samples settled outputs on the falling edge.
    always @(negedge clk) begin
        ent_t e;
        if (!reset_pyri) begin
            chk("rst_req_valid", 64'(bus.imem_req_valid_pyro), 64'd0);
            chk("rst_inst_valid", 64'(bus.inst_valid_pyro), 64'd0);
            if (rst_edges > 0) begin
                chk("rst_req_addr", bus.imem_req_addr_pyro, RESET_PC);
                chk("rst_pc", bus.pc_pyro, 64'd0);
                chk("rst_inst", 64'(bus.inst_pyro), 64'd0);
            end
            redir_prev = 0;
            prev_stall = 0;
        end else begin
            if (redir_prev && !bus.redirect_valid_pyri) begin
                chk("redirect_req_valid", 64'(bus.imem_req_valid_pyro), 64'd1);
                chk("redirect_req_addr", bus.imem_req_addr_pyro, redir_tgt);
                chk("redirect_flush", 64'(bus.inst_valid_pyro), 64'd0);
            end
            if (prev_stall && !bus.redirect_valid_pyri && !prev_rsp_ctrl) begin
                chk("retry_hold_valid", 64'(bus.imem_req_valid_pyro), 64'd1);
                chk("retry_hold_addr", bus.imem_req_addr_pyro, prev_addr);
            end
            if (walk_stop && exp_q.size() == 0 && !bus.redirect_valid_pyri && !redir_prev)
                chk("waitbr_noreq", 64'(bus.imem_req_valid_pyro), 64'd0);
            if (bus.inst_valid_pyro && !bus.inst_retry_pyri && !bus.redirect_valid_pyri) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got pc %h inst %h, required no output",
                             bus.pc_pyro, bus.inst_pyro);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", bus.pc_pyro, e.pc);
                    chk("out_inst", 64'(bus.inst_pyro), 64'(e.inst));
                    extend();
                end
            end
            if (bus.imem_req_valid_pyro && !bus.imem_req_retry_pyri)
                pend_q.push_back('{bus.imem_req_addr_pyro, cyc + 1 + $urandom_range(0, max_lat)});
            if (phase == 0) chk("outstanding_bound", 64'(pend_q.size() <= DEPTH), 64'd1);
            redir_prev    = bus.redirect_valid_pyri;
            redir_tgt     = bus.redirect_pc_pyri;
            prev_stall    = bus.imem_req_valid_pyro && bus.imem_req_retry_pyri;
            prev_addr     = bus.imem_req_addr_pyro;
            prev_rsp_ctrl = bus.imem_rsp_valid_pyri && rsp_ctrl;
        end
    end

    initial begin
        logic [63:0] tgt;
        int idle, idle_limit, hs_mark;
        reset_pyri              = 1'b0;
        bus.redirect_valid_pyri = 1'b0;
        bus.redirect_pc_pyri    = '0;
        bus.imem_req_retry_pyri = 1'b0;
        bus.imem_rsp_valid_pyri = 1'b0;
        bus.imem_rsp_data_pyri  = '0;
        bus.inst_retry_pyri     = 1'b0;
        start_walk(RESET_PC);

        // Free run with NOPs and a zero-latency memory.
        repeat (3) step(1'b0, '0);
        reset_pyri = 1'b1;
        repeat (30) step(1'b0, '0);
        chk("free_run_throughput", 64'(hs_count >= 25), 64'd1);

        // Decode back-pressure fills the queue, then drains in order.
        phase = 1;
        hold_dec_retry = 1;
        repeat (10) step(1'b0, '0);
        @(negedge clk);
        chk("full_inst_valid", 64'(bus.inst_valid_pyro), 64'd1);
        chk("full_req_valid", 64'(bus.imem_req_valid_pyro), 64'd0);
        chk("full_outstanding", 64'(pend_q.size()), 64'd0);
        hold_dec_retry = 0;
        hs_mark = hs_count;
        repeat (20) step(1'b0, '0);
        chk("drain_progress", 64'(hs_count - hs_mark >= 15), 64'd1);

        // Random program with jumps, stops, redirects, retries and latency.
        phase = 2;
        prog_mode = 1;
        mem_retry_pct = 20;
        dec_retry_pct = 25;
        rsp_stall_pct = 15;
        max_lat = 3;
        step(1'b1, 64'h8000_1000);
        idle = 0;
        idle_limit = 10;
        hs_mark = hs_count;
        for (int i = 0; i < 3000; i++) begin
            tgt = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
            if ($urandom_range(0, 15) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0;
            if (walk_stop && exp_q.size() == 0) idle++;
            if (idle >= idle_limit || $urandom_range(0, 59) == 0) begin
                idle = 0;
                idle_limit = $urandom_range(3, 25);
                step(1'b1, tgt);
            end else begin
                step(1'b0, '0);
            end
        end
        step(1'b0, '0);
        chk("random_progress", 64'(hs_count - hs_mark >= 300), 64'd1);

        // Reset mid-operation, then stray responses with nothing in flight.
        phase = 3;
        hold_dec_retry = 1;
        repeat (8) step(1'b0, '0);
        reset_pyri = 1'b0;
        hold_mem_retry = 1;
        hold_dec_retry = 0;
        pend_q.delete();
        start_walk(RESET_PC);
        repeat (2) step(1'b0, '0);
        reset_pyri = 1'b1;
        spurious = 1;
        repeat (3) step(1'b0, '0);
        spurious = 0;
        step(1'b0, '0);
        @(negedge clk);
        chk("stray_rsp_ignored", 64'(bus.inst_valid_pyro), 64'd0);
        chk("post_reset_req_valid", 64'(bus.imem_req_valid_pyro), 64'd1);
        chk("post_reset_req_addr", bus.imem_req_addr_pyro, RESET_PC);
        hold_mem_retry = 0;
        hs_mark = hs_count;
        for (int i = 0; i < 400; i++) step(($urandom_range(0, 79) == 0), 64'h8000_0400);
        step(1'b0, '0);
        chk("post_reset_progress", 64'(hs_count - hs_mark >= 20), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
